// File: rtl/uart_pkg.sv
// Definitions shared by the UART receive and transmit paths: FSM state encoding
// and the oversample clock-divider computation.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    // System clocks per oversample tick, truncated toward zero.
    function automatic int calc_div(input int clk_freq_hz, input int baud, input int oversample);
        return clk_freq_hz / (baud * oversample);
    endfunction

endpackage

// File: rtl/uart_os_tick_gen.sv
// Free-running mod-DIV divider; os_tick pulses for one clk every DIV clks and never stops.
module uart_os_tick_gen #(
    parameter int DIV = 325
) (
    input  logic clk,
    input  logic reset,
    output logic os_tick
);

    localparam int            CW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        // NOTE: cnt_d gets a default before any condition, so no path leaves it unassigned and no latch is inferred.
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign os_tick = (cnt_q == CNT_LAST);

endmodule

// File: rtl/uart_rx_bit_sampler.sv
// UART receive front end: synchronises rx, qualifies the start bit, samples data bits at
// mid-bit and emits each bit with a registered one-clk strobe, plus end-of-frame status.
module uart_rx_bit_sampler
    import uart_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int BAUD        = 9600,
    parameter int OVERSAMPLE  = 16,
    parameter int DATA_BITS   = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic rx_in,
    output logic bit_out,
    output logic bit_tick,
    output logic frame_done,
    output logic frame_error,
    output logic busy
);

    localparam int DIV = calc_div(CLK_FREQ_HZ, BAUD, OVERSAMPLE);
    localparam int OW  = $clog2(OVERSAMPLE);
    localparam int BW  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [OW-1:0] OS_MID   = OW'(OVERSAMPLE / 2 - 1);
    localparam logic [OW-1:0] OS_LAST  = OW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

    logic        sync1_q;
    logic        rx_s_q;
    logic        os_tick;

    uart_state_e state_q;
    logic        armed_q;
    logic [OW-1:0] os_cnt_q;
    logic [BW-1:0] bit_idx_q;
    logic        sample_pend_q;
    logic        bit_out_q;
    logic        bit_tick_q;
    logic        frame_done_q;
    logic        frame_error_q;

    // Two-flop synchroniser; resets to the idle-high line level.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b1;
            rx_s_q  <= 1'b1;
        end else begin
            // NOTE: non-blocking so rx_s_q takes the old sync1_q, giving two real flop stages.
            sync1_q <= rx_in;
            rx_s_q  <= sync1_q;
        end
    end

    uart_os_tick_gen #(
        .DIV (DIV)
    ) u_os_tick_gen (
        .clk     (clk),
        .reset   (reset),
        .os_tick (os_tick)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            armed_q       <= 1'b0;
            os_cnt_q      <= '0;
            bit_idx_q     <= '0;
            sample_pend_q <= 1'b0;
            bit_out_q     <= 1'b1;
            bit_tick_q    <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            // Strobe lags the bit_out update by one clk so the SIPO sees settled data.
            bit_tick_q    <= sample_pend_q;
            sample_pend_q <= 1'b0;
            frame_done_q  <= 1'b0;
            if (os_tick) begin
                unique case (state_q)
                    ST_IDLE: begin
                        if (rx_s_q) begin
                            armed_q <= 1'b1;
                        end else if (armed_q) begin
                            state_q  <= ST_START;
                            os_cnt_q <= '0;
                        end
                    end
                    ST_START: begin
                        if (os_cnt_q == OS_MID) begin
                            os_cnt_q <= '0;
                            if (rx_s_q) begin
                                state_q <= ST_IDLE;
                            end else begin
                                state_q   <= ST_DATA;
                                bit_idx_q <= '0;
                            end
                        end else begin
                            os_cnt_q <= os_cnt_q + OW'(1);
                        end
                    end
                    ST_DATA: begin
                        if (os_cnt_q == OS_LAST) begin
                            os_cnt_q      <= '0;
                            bit_out_q     <= rx_s_q;
                            sample_pend_q <= 1'b1;
                            if (bit_idx_q == BIT_LAST) begin
                                state_q <= ST_STOP;
                            end else begin
                                bit_idx_q <= bit_idx_q + BW'(1);
                            end
                        end else begin
                            os_cnt_q <= os_cnt_q + OW'(1);
                        end
                    end
                    ST_STOP: begin
                        if (os_cnt_q == OS_LAST) begin
                            os_cnt_q      <= '0;
                            frame_done_q  <= 1'b1;
                            frame_error_q <= ~rx_s_q;
                            // A low stop bit leaves IDLE unarmed so a break cannot start a frame.
                            armed_q       <= rx_s_q;
                            state_q       <= ST_IDLE;
                        end else begin
                            os_cnt_q <= os_cnt_q + OW'(1);
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign bit_out     = bit_out_q;
    assign bit_tick    = bit_tick_q;
    assign frame_done  = frame_done_q;
    assign frame_error = frame_error_q;
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_bit_sampler.sv
// Self-checking bench: a tick-schedule reference model is compared with the DUT every cycle,
// alongside directed frames and randomized traffic with literal byte/flag expectations.
module tb_uart_rx_bit_sampler;

    localparam int CLK_HZ = 1_600_000;
    localparam int BAUD   = 10_000;
    localparam int OS     = 16;
    localparam int NBITS  = 8;
    localparam int DIV    = CLK_HZ / (BAUD * OS);
    localparam int CPB    = OS * DIV;

    logic clk;
    logic rst_n;
    logic rx_in;
    logic bit_out;
    logic bit_tick;
    logic frame_done;
    logic frame_error;
    logic busy;

    int vectors;
    int miscompares;
    int cyc;

    uart_rx_bit_sampler #(
        .CLK_FREQ_HZ (CLK_HZ),
        .BAUD        (BAUD),
        .OVERSAMPLE  (OS),
        .DATA_BITS   (NBITS)
    ) dut (
        .clk         (clk),
        .reset       (rst_n),
        .rx_in       (rx_in),
        .bit_out     (bit_out),
        .bit_tick    (bit_tick),
        .frame_done  (frame_done),
        .frame_error (frame_error),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int actual, input int expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Reference model: bit decisions are placed at absolute os-tick offsets from the start
    // detection tick (mid start at +OS/2, data k at +OS/2+k*OS, stop at +OS/2+(NBITS+1)*OS).
    bit       m_busy, m_armed, m_pend, d1, d2;
    bit       e_bit, e_tick, e_done, e_err;
    int       edge_cnt, tick_idx, t0;
    logic [7:0] m_sh;
    logic [7:0] m_bytes[$];
    bit       m_errs[$];

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                edge_cnt = 0; tick_idx = 0; t0 = 0;
                m_busy = 0; m_armed = 0; m_pend = 0; d1 = 1; d2 = 1;
                e_bit = 1; e_tick = 0; e_done = 0; e_err = 0; m_sh = '0;
            end else begin
                bit s;
                int rel, k;
                s  = d2;
                d2 = d1;
                d1 = rx_in;
                e_tick = m_pend;
                m_pend = 0;
                e_done = 0;
                if (edge_cnt % DIV == DIV - 1) begin
                    if (!m_busy) begin
                        if (s) m_armed = 1;
                        else if (m_armed) begin m_busy = 1; t0 = tick_idx; end
                    end else begin
                        rel = tick_idx - t0;
                        if (rel == OS / 2 && s) begin
                            m_busy = 0;
                        end else if (rel > OS / 2 && (rel - OS / 2) % OS == 0) begin
                            k = (rel - OS / 2) / OS;
                            if (k <= NBITS) begin
                                e_bit  = s;
                                m_pend = 1;
                                m_sh   = {s, m_sh[7:1]};
                            end else begin
                                e_done  = 1;
                                e_err   = !s;
                                m_busy  = 0;
                                m_armed = s;
                                m_bytes.push_back(m_sh);
                                m_errs.push_back(!s);
                            end
                        end
                    end
                    tick_idx++;
                end
                edge_cnt++;
            end
        end
    end

    // Per-cycle compare plus a SIPO reconstruction of what the DUT delivered.
    logic [7:0] sh;
    int         nbits, tick_total, dut_frames, last_tick, first_tick_cyc;
    logic [7:0] dut_bytes[$];
    bit         dut_errs[$];

    initial begin
        forever begin
            @(negedge clk);
            check("outputs", {bit_out, bit_tick, frame_done, frame_error, busy},
                  {e_bit, e_tick, e_done, e_err, m_busy});
            if (!rst_n) begin
                sh = '0;
                nbits = 0;
            end else begin
                if (bit_tick) begin
                    if (nbits > 0) check("tick_spacing", cyc - last_tick, CPB);
                    else first_tick_cyc = cyc;
                    last_tick = cyc;
                    sh = {bit_out, sh[7:1]};
                    nbits++;
                    tick_total++;
                end
                if (frame_done) begin
                    dut_bytes.push_back(sh);
                    dut_errs.push_back(frame_error);
                    dut_frames++;
                    nbits = 0;
                end
            end
        end
    end

    int last_fall_cyc;

    task automatic drive_bit(input logic v, input int cpb);
        rx_in = v;
        repeat (cpb) @(negedge clk);
    endtask

    task automatic idle(input int n);
        rx_in = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] data, input logic stop, input int cpb);
        last_fall_cyc = cyc;
        drive_bit(1'b0, cpb);
        for (int i = 0; i < NBITS; i++) drive_bit(data[i], cpb);
        drive_bit(stop, cpb);
        rx_in = 1'b1;
    endtask

    task automatic wait_frames(input int n);
        int budget;
        budget = 400;
        while (dut_frames < n && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check("frame_count", dut_frames, n);
    endtask

    task automatic expect_last(input string name, input logic [7:0] data, input bit err);
        check({name, "_byte"}, dut_bytes[$], data);
        check({name, "_err"}, dut_errs[$], err);
        check({name, "_model_byte"}, m_bytes[$], data);
        check({name, "_model_err"}, m_errs[$], err);
    endtask

    int base_f, base_t;

    initial begin
        vectors = 0; miscompares = 0; cyc = 0;
        tick_total = 0; dut_frames = 0; nbits = 0; sh = '0; last_tick = 0; first_tick_cyc = 0;
        rst_n = 1'b0;
        rx_in = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_bit_out", bit_out, 1);
        check("reset_flags", {bit_tick, frame_done, frame_error, busy}, 0);
        rst_n = 1'b1;
        idle(40);

        // Frame 0xA5: latency, tick count, byte and status.
        base_f = dut_frames; base_t = tick_total;
        send_frame(8'hA5, 1'b1, CPB);
        idle(50);
        wait_frames(base_f + 1);
        expect_last("a5", 8'hA5, 1'b0);
        check("a5_ticks", tick_total - base_t, 8);
        check("a5_latency_ok", int'((first_tick_cyc - last_fall_cyc) inside {[233:253]}), 1);
        check("a5_busy_after", busy, 0);

        // Short low glitch is rejected, then a normal frame is accepted.
        base_f = dut_frames; base_t = tick_total;
        drive_bit(1'b0, 3 * DIV);
        idle(200);
        check("glitch_ticks", tick_total - base_t, 0);
        check("glitch_frames", dut_frames - base_f, 0);
        check("glitch_busy", busy, 0);
        send_frame(8'h5A, 1'b1, CPB);
        idle(50);
        wait_frames(base_f + 1);
        expect_last("post_glitch", 8'h5A, 1'b0);

        // Framing error followed by a break, then a clean frame.
        base_f = dut_frames;
        send_frame(8'h00, 1'b0, CPB);
        drive_bit(1'b0, 3 * CPB);
        idle(CPB);
        check("break_frames", dut_frames - base_f, 1);
        expect_last("ferr", 8'h00, 1'b1);
        send_frame(8'h3C, 1'b1, CPB);
        idle(50);
        wait_frames(base_f + 2);
        expect_last("after_break", 8'h3C, 1'b0);

        // Reset after the third bit_tick of 0xFF.
        base_f = dut_frames; base_t = tick_total;
        fork
            begin
                send_frame(8'hFF, 1'b1, CPB);
                idle(200);
            end
            begin
                int budget;
                budget = 3000;
                while (tick_total < base_t + 3 && budget > 0) begin
                    @(negedge clk);
                    budget--;
                end
                check("rst_third_tick_seen", tick_total - base_t, 3);
                rst_n = 1'b0;
                #1;
                check("rst_mid_bit_out", bit_out, 1);
                check("rst_mid_busy", busy, 0);
                check("rst_mid_tick", bit_tick, 0);
                repeat (5) @(negedge clk);
                rst_n = 1'b1;
            end
        join
        check("rst_no_more_ticks", tick_total - base_t, 3);
        check("rst_no_frame", dut_frames - base_f, 0);
        send_frame(8'h3C, 1'b1, CPB);
        idle(50);
        wait_frames(base_f + 1);
        expect_last("post_reset", 8'h3C, 1'b0);

        // Back-to-back frames with a single stop bit each.
        base_f = dut_frames; base_t = tick_total;
        send_frame(8'h55, 1'b1, CPB);
        send_frame(8'hF0, 1'b1, CPB);
        idle(50);
        wait_frames(base_f + 2);
        check("b2b_ticks", tick_total - base_t, 16);
        check("b2b_first", dut_bytes[base_f], 8'h55);
        check("b2b_first_err", dut_errs[base_f], 0);
        expect_last("b2b_second", 8'hF0, 1'b0);

        // Baud tolerance: +/-3% must decode, +6% must be flagged, clean frame recovers.
        base_f = dut_frames;
        send_frame(8'h81, 1'b1, 155);
        idle(100);
        wait_frames(base_f + 1);
        expect_last("fast3", 8'h81, 1'b0);
        send_frame(8'h81, 1'b1, 165);
        idle(100);
        wait_frames(base_f + 2);
        expect_last("slow3", 8'h81, 1'b0);
        send_frame(8'h81, 1'b1, 150);
        idle(200);
        wait_frames(base_f + 3);
        check("fast6_flagged", int'(dut_bytes[$] != 8'h81 || dut_errs[$]), 1);
        send_frame(8'h81, 1'b1, 170);
        idle(200);
        wait_frames(base_f + 4);
        send_frame(8'h81, 1'b1, CPB);
        idle(100);
        wait_frames(base_f + 5);
        expect_last("recover", 8'h81, 1'b0);

        // Randomized traffic with small baud offsets and occasional bad stop bits.
        for (int n = 0; n < 10; n++) begin
            logic [7:0] data;
            logic       stop;
            int         gap;
            data = 8'($urandom);
            stop = ($urandom_range(0, 5) != 0);
            gap  = stop ? $urandom_range(0, 200) : $urandom_range(40, 200);
            base_f = dut_frames;
            send_frame(data, stop, $urandom_range(157, 163));
            idle(gap);
            wait_frames(base_f + 1);
            expect_last("rand", data, !stop);
        end

        idle(100);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
